tl_d_beat_queue: RTL and testbench
==================================

// Module: tl_d_beat_queue
// PURPOSE
//  12-entry FIFO for TileLink D-channel response beats (data + corrupt + last), feeding the consumer stage.
//  Sits between the D-channel arbiter and the refill/response consumer.
//  Per-beat corrupt bits live in a 12x1 corrupt RAM.
//  Also tracks a sticky per-burst corrupt flag and a saturating count of corrupt beats dequeued.
// PARAMETERS
//  DATA_W  64  beat payload width in bits
//  DEPTH   12  entries; non-power-of-2, pointers wrap explicitly
//  CNT_W   8   width of the saturating corrupt-beat counter
// PORTS
//  clock              in   1       sole clock, all state on posedge
//  reset              in   1       asynchronous, active-low; 0 = in reset
//  enq_valid          in   1       upstream beat valid
//  enq_ready          out  1       queue can accept a beat
//  enq_data           in   DATA_W  beat payload
//  enq_corrupt        in   1       beat marked corrupt
//  enq_last           in   1       final beat of its burst
//  deq_valid          out  1       head beat valid
//  deq_ready          in   1       downstream accepts head
//  deq_data           out  DATA_W  head payload
//  deq_corrupt        out  1       head corrupt bit
//  deq_last           out  1       head last flag
//  deq_burst_corrupt  out  1       OR of corrupt over this burst's dequeued beats, including head
//  count              out  4       occupancy, 0..DEPTH
//  corrupt_cnt        out  CNT_W   corrupt beats dequeued since reset/clear, saturating
//  clear_cnt          in   1       synchronous clear of corrupt_cnt
// BEHAVIOUR
//  Fires and flags
//   - enq_fire = enq_valid & enq_ready; deq_fire = deq_valid & deq_ready.
//   - enq_ready = reset & (count != DEPTH); deq_valid = (count != 0).
//  While reset is low (asynchronous)
//   - head_ptr, tail_ptr, count, burst_sticy, corrupt_cnt are 0.
//   - enq_ready = 0, deq_valid = 0.
//   - deq_burst_corrupt = 0 (gated by deq_valid).
//   - Storage contents are not reset. deq_data, deq_corrupt and deq_last are don't-care while deq_valid = 0.
//   - Reset mid-burst discards all entries and the sticky flag.
//  Pointers and occupancy
//   - Pointers are 4-bit and range 0..11; increment wraps 11 -> 0.
//   - enq_fire: write the beat at tail_ptr, then tail_ptr advances.
//   - deq_fire: head_ptr advances.
//   - count += enq_fire - deq_fire.
//  Latency
//   - Read is combinational from head_ptr.
//   - A beat enqueued in cycle N is visible on deq_* in cycle N+1. No same-cycle bypass.
//  Simultaneous events
//   - Full: enq_ready = 0, so only deq can fire. No write-through while full.
//   - Empty: only enq can fire.
//   - Enq and deq in the same cycle at 0 < count < DEPTH leaves count unchanged. Both pointers advance.
//  Handshake rules
//   - Once deq_valid = 1, deq_valid and the head contents stay stable until deq_fire.
//   - enq_* are sampled only on enq_fire.
//  Burst corrupt tracking
//   - deq_burst_corrupt = deq_valid & (burst_sticky | deq_corrupt).
//   - On deq_fire with deq_last = 0: burst_sticky <= burst_sticky | deq_corrupt.
//   - On deq_fire with deq_last = 1: burst_sticky <= 0.
//  Corrupt counter
//   - On deq_fire & deq_corrupt: corrupt_cnt increments, saturating at 2^CNT_W-1.
//   - clear_cnt has priority over the old value: next = (deq_fire & deq_corrupt) ? 1 : 0.
// STRUCTURE
//  Package tl_d_queue_pkg
//   - DEPTH and PTR_W = 4.
//   - typedef struct packed { logic [DATA_W-1:0] data; logic corrupt; logic last; } d_beat_t
//   - Function ptr_inc(): wrap at DEPTH-1.
//  Sub-module tl_d_beat_ram
//   - DEPTH x (DATA_W+2) storage.
//   - One synchronous write port (W0_*), one combinational read port (R0_*).
//   - Corrupt bit mapped to a 12x1 corrupt RAM.
//   - Top level holds pointers, count, sticky flag and counter.
// TESTING
//  1. Release reset; enq 3 beats (data 0xA, 0xB, 0xC; corrupt 0; last on 3rd), deq_ready = 1.
//     -> deq order A, B, C from cycle+1; deq_last only on C; count returns to 0.
//  2. Enq 12 beats with deq_ready = 0.
//     -> count = 12, enq_ready = 0.
//     Then 12th+1 enq_valid held and deq_ready = 1 for 1 cycle.
//     -> head (beat 0) leaves; new beat written at slot 0 (wrap) the next cycle.
//  3. Burst of 4 beats, corrupt only on beat 1.
//     -> deq_burst_corrupt = 0, 1, 1, 1 on beats 0..3.
//     Next burst's beat 0 without corrupt -> deq_burst_corrupt = 0.
//  4. Hold enq_fire and deq_fire every cycle for 30 cycles at count = 5.
//     -> count stays 5; data arrives in order across pointer wrap 11 -> 0.
//  5. Dequeue 300 corrupt beats.
//     -> corrupt_cnt saturates at 255.
//     clear_cnt together with a corrupt deq_fire -> corrupt_cnt = 1.
//  6. Assert reset with count = 7 mid-burst, sticky = 1.
//     -> deq_valid = 0, count = 0, deq_burst_corrupt = 0, enq_ready = 0, asynchronously.
//     After release -> enq_ready = 1.

Source files
------------

// File: rtl/tl_d_queue_pkg.sv
// tl_d_queue_pkg: shared sizing, beat layout and pointer helper for the D-beat queue
package tl_d_queue_pkg;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 12;
    localparam int PTR_W  = 4;
    localparam int CNT_W  = 8;
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              corrupt;
        logic              last;
    } d_beat_t;
    // Depth is not a power of two, so the wrap must be explicit.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction
endpackage

// File: rtl/tl_d_beat_ram.sv
// tl_d_beat_ram: beat storage with one synchronous write port and one combinational read port
module tl_d_beat_ram
    import tl_d_queue_pkg::*;
(
    input  logic             clock,
    input  logic             W0_en,
    input  logic [PTR_W-1:0] W0_addr,
    input  d_beat_t          W0_data,
    input  logic [PTR_W-1:0] R0_addr,
    output d_beat_t          R0_data
);
    logic [DATA_W:0] main_mem [DEPTH];
    // Corrupt bits are kept in their own narrow array.
    logic            corrupt_mem [DEPTH];
    always_ff @(posedge clock)
        if (W0_en) begin
            main_mem[W0_addr]    <= {W0_data.data, W0_data.last};
            corrupt_mem[W0_addr] <= W0_data.corrupt;
        end
    assign R0_data = '{data: main_mem[R0_addr][DATA_W:1],
                       corrupt: corrupt_mem[R0_addr],
                       last: main_mem[R0_addr][0]};
endmodule

// File: rtl/tl_d_beat_queue.sv
// tl_d_beat_queue: 12-entry TileLink D-beat FIFO with burst-corrupt tracking and a corrupt-beat counter
module tl_d_beat_queue
    import tl_d_queue_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              enq_corrupt,
    input  logic              enq_last,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_data,
    output logic              deq_corrupt,
    output logic              deq_last,
    output logic              deq_burst_corrupt,
    output logic [3:0]        count,
    output logic [CNT_W-1:0]  corrupt_cnt,
    input  logic              clear_cnt
);
    logic [PTR_W-1:0] head_ptr, tail_ptr;
    logic             burst_sticky, enq_fire, deq_fire, cnt_hit;
    d_beat_t          enq_beat, head;
    assign enq_ready         = reset & (count != 4'(DEPTH));
    assign deq_valid         = count != '0;
    assign enq_fire          = enq_valid & enq_ready;
    assign deq_fire          = deq_valid & deq_ready;
    assign enq_beat          = '{data: enq_data, corrupt: enq_corrupt, last: enq_last};
    assign {deq_data, deq_corrupt, deq_last} = head;
    assign deq_burst_corrupt = deq_valid & (burst_sticky | deq_corrupt);
    assign cnt_hit           = deq_fire & deq_corrupt;
    tl_d_beat_ram u_ram (
        .clock   (clock),
        .W0_en   (enq_fire),
        .W0_addr (tail_ptr),
        .W0_data (enq_beat),
        .R0_addr (head_ptr),
        .R0_data (head)
    );
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            head_ptr     <= '0;
            tail_ptr     <= '0;
            count        <= '0;
            burst_sticky <= 1'b0;
            corrupt_cnt  <= '0;
        end else begin
            if (enq_fire) tail_ptr <= ptr_inc(tail_ptr);
            if (deq_fire) head_ptr <= ptr_inc(head_ptr);
            if (deq_fire) burst_sticky <= deq_last ? 1'b0 : (burst_sticky | deq_corrupt);
            count       <= count + 4'(enq_fire) - 4'(deq_fire);
            corrupt_cnt <= clear_cnt ? CNT_W'(cnt_hit) :
                           (cnt_hit && corrupt_cnt != '1) ? corrupt_cnt + CNT_W'(1) : corrupt_cnt;
        end
endmodule

// File: tb/tb_tl_d_beat_queue.sv
// tb_tl_d_beat_queue: scoreboard bench; stimulus pushes expected beats, a negedge monitor pops and checks
module tb_tl_d_beat_queue;
    logic        clock = 0, reset, enq_valid, enq_ready, enq_corrupt, enq_last;
    logic        deq_valid, deq_ready, deq_corrupt, deq_last, deq_burst_corrupt, clear_cnt;
    logic [63:0] enq_data, deq_data;
    logic [3:0]  count;
    logic [7:0]  corrupt_cnt;
    typedef struct {
        logic [63:0] d;
        logic        c, l, bc;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0, n_bad = 0, m_count = 0, m_cc = 0;
    logic ef, df, hc;

    tl_d_beat_queue dut (
        .clock(clock), .reset(reset), .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_data(enq_data), .enq_corrupt(enq_corrupt), .enq_last(enq_last),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
        .deq_corrupt(deq_corrupt), .deq_last(deq_last), .deq_burst_corrupt(deq_burst_corrupt),
        .count(count), .corrupt_cnt(corrupt_cnt), .clear_cnt(clear_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic enq_beat(input logic [63:0] d, input logic c, input logic l, input logic bc);
        enq_valid = 1; enq_data = d; enq_corrupt = c; enq_last = l;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (enq_ready) begin
                sb.push_back('{d, c, l, bc});
                @(posedge clock); #1;
                return;
            end
        end
        n_cmp++; n_bad++;
        $display("FAIL enq_timeout: got enq_ready=0 for 64 cycles expected 1, data %0h", d);
        enq_valid = 0;
    endtask

    task automatic drain();
        deq_ready = 1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && !deq_valid) begin
                @(posedge clock); #1;
                return;
            end
        end
        n_cmp++; n_bad++;
        $display("FAIL drain_timeout: got %0d beats left expected 0", sb.size());
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            chk("rst_deq_valid", deq_valid, 0);
            chk("rst_enq_ready", enq_ready, 0);
            chk("rst_burst_corrupt", deq_burst_corrupt, 0);
            chk("rst_count", count, 0);
            chk("rst_corrupt_cnt", corrupt_cnt, 0);
            m_count = 0; m_cc = 0;
            sb.delete();
        end else begin
            ef = enq_valid && m_count != 12;
            df = deq_ready && m_count != 0;
            chk("deq_valid", deq_valid, m_count != 0);
            chk("enq_ready", enq_ready, m_count != 12);
            chk("count", count, m_count);
            chk("corrupt_cnt", corrupt_cnt, m_cc);
            hc = 0;
            if (deq_valid && deq_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_deq: got data %0h expected no beat", deq_data);
                end else begin
                    e = sb.pop_front();
                    chk("deq_data", deq_data, e.d);
                    chk("deq_corrupt", deq_corrupt, e.c);
                    chk("deq_last", deq_last, e.l);
                    chk("deq_burst_corrupt", deq_burst_corrupt, e.bc);
                    hc = e.c;
                end
            end
            m_cc = clear_cnt ? ((df && hc) ? 1 : 0) : (df && hc && m_cc != 255) ? m_cc + 1 : m_cc;
            m_count = m_count + int'(ef) - int'(df);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000");
        $fatal(1);
    end

    initial begin
        reset = 0; enq_valid = 0; enq_data = 0; enq_corrupt = 0; enq_last = 0;
        deq_ready = 0; clear_cnt = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1;
        // three-beat burst, streamed straight through
        deq_ready = 1;
        enq_beat(64'hA, 0, 0, 0);
        enq_beat(64'hB, 0, 0, 0);
        enq_beat(64'hC, 0, 1, 0);
        enq_valid = 0;
        drain();
        chk("t1_count", count, 0);
        // fill to full, then one dequeue frees the slot for a held beat
        deq_ready = 0;
        for (int i = 0; i < 12; i++) enq_beat(64'h200 + 64'(i), 0, 1, 0);
        enq_data = 64'h20C;
        chk("t2_full_count", count, 12);
        chk("t2_full_enq_ready", enq_ready, 0);
        deq_ready = 1;
        @(posedge clock); #1;
        deq_ready = 0;
        chk("t2_after_deq_count", count, 11);
        enq_beat(64'h20C, 0, 1, 0);
        enq_valid = 0;
        chk("t2_refill_count", count, 12);
        drain();
        // burst corrupt: corrupt on beat 1 of 4, then a clean single-beat burst
        deq_ready = 0;
        enq_beat(64'h300, 0, 0, 0);
        enq_beat(64'h301, 1, 0, 1);
        enq_beat(64'h302, 0, 0, 1);
        enq_beat(64'h303, 0, 1, 1);
        enq_beat(64'h310, 0, 1, 0);
        enq_valid = 0;
        drain();
        // steady state at count 5 with enqueue and dequeue every cycle
        deq_ready = 0;
        for (int i = 0; i < 5; i++) enq_beat(64'h400 + 64'(i), 0, 1, 0);
        deq_ready = 1;
        for (int i = 0; i < 30; i++) enq_beat(64'h500 + 64'(i), 0, 1, 0);
        enq_valid = 0;
        chk("t4_count", count, 5);
        drain();
        // counter saturation, then clear together with a corrupt dequeue
        deq_ready = 1;
        for (int i = 0; i < 300; i++) enq_beat(64'h600 + 64'(i), 1, 1, 1);
        enq_valid = 0;
        chk("t5_saturated", corrupt_cnt, 255);
        clear_cnt = 1;
        @(posedge clock); #1;
        clear_cnt = 0;
        chk("t5_clear_with_hit", corrupt_cnt, 1);
        chk("t5_count", count, 0);
        // asynchronous reset mid-burst with sticky set
        deq_ready = 0;
        enq_beat(64'h700, 1, 0, 1);
        for (int i = 1; i < 8; i++) enq_beat(64'h700 + 64'(i), 0, 0, 1);
        enq_valid = 0;
        deq_ready = 1;
        @(posedge clock); #1;
        deq_ready = 0;
        chk("t6_count", count, 7);
        chk("t6_sticky", deq_burst_corrupt, 1);
        #2 reset = 0;
        #1;
        chk("t6_async_deq_valid", deq_valid, 0);
        chk("t6_async_count", count, 0);
        chk("t6_async_burst", deq_burst_corrupt, 0);
        chk("t6_async_enq_ready", enq_ready, 0);
        @(posedge clock); #1 reset = 1;
        @(negedge clock);
        chk("t6_release_enq_ready", enq_ready, 1);
        chk("t6_release_count", count, 0);
        chk("t6_scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
